v_hier_qvec_pack: RTL

- Sits directly downstream of v_hier_sub and consumes its 4-bit qvec result stream.
- Packs consecutive valid qvec nibbles, LSB-first, into 32-bit words.
- Buffers complete words in a small FIFO.
- Presents words on a valid/ready interface to the next consumer, with a level count and a sticky overflow flag.

---
 rtl/v_hier_qvec_pack_pkg.sv | 10 +
 rtl/v_hier_qvec_pack_if.sv | 25 ++
 rtl/v_hier_qvec_pack_fifo.sv | 60 ++++++
 rtl/v_hier_qvec_pack.sv | 65 ++++++
 4 files changed

// File: rtl/v_hier_qvec_pack_pkg.sv
// rtl/v_hier_qvec_pack_pkg.sv - shared widths and types for the qvec word packer
package v_hier_pkg;
  localparam int NIB_W         = 4;
  localparam int NIBS_PER_WORD = 8;
  localparam int WORD_W        = NIB_W * NIBS_PER_WORD;
  localparam int PACK_W        = WORD_W - NIB_W;

  typedef logic [NIB_W-1:0]  nib_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/v_hier_qvec_pack_if.sv
// rtl/v_hier_qvec_pack_if.sv - nibble input, word output and status bundle of the packer
interface v_hier_qvec_pack_if
  import v_hier_pkg::*;
#(
  parameter int LVL_W = 3
);
  logic             qvec_vld;
  nib_t             qvec;
  logic             flush;
  word_t            out_data;
  logic             out_vld;
  logic             out_rdy;
  logic [LVL_W-1:0] level;
  logic             ovf;

  modport master (
    output qvec_vld, qvec, flush, out_rdy,
    input  out_data, out_vld, level, ovf
  );

  modport slave (
    input  qvec_vld, qvec, flush, out_rdy,
    output out_data, out_vld, level, ovf
  );
endinterface

// File: rtl/v_hier_qvec_pack_fifo.sv
// rtl/v_hier_qvec_pack_fifo.sv - first-word-fall-through word FIFO with push-while-full-and-popping support
module v_hier_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic [W-1:0]     o_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [LVL_W-1:0] r_level;
  logic             r_vld;
  logic             w_pop;
  logic             w_push;
  logic [LVL_W-1:0] w_level_nxt;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = !r_vld;
  assign o_level = r_level;
  assign o_data  = r_vld ? r_mem[r_rd] : '0;

  // A pop frees the slot on the same edge, so a full FIFO may still take a push.
  assign w_pop  = i_pop && r_vld;
  assign w_push = i_push && (!o_full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (w_pop && !w_push) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_vld   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_level <= w_level_nxt;
      r_vld   <= (w_level_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/v_hier_qvec_pack.sv
// rtl/v_hier_qvec_pack.sv - packs valid qvec nibbles LSB-first into words and buffers them for the consumer
module v_hier_qvec_pack
  import v_hier_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  v_hier_qvec_pack_if.slave  bus
);
  localparam int CNT_W = $clog2(NIBS_PER_WORD);

  logic [CNT_W-1:0]  r_nib_cnt;
  logic [PACK_W-1:0] r_pack;
  logic              r_ovf;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  word_t             w_word;

  assign w_last = (r_nib_cnt == CNT_W'(NIBS_PER_WORD - 1));
  assign w_push = bus.qvec_vld && !bus.flush && w_last;
  assign w_pop  = bus.out_rdy && !w_empty;
  // The final nibble bypasses r_pack so the word is pushed on the edge it arrives.
  assign w_word = {bus.qvec, r_pack};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_cnt <= '0;
      r_pack    <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.flush) begin
      r_nib_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (bus.qvec_vld) begin
        if (!w_last) r_pack[{r_nib_cnt, 2'b00} +: NIB_W] <= bus.qvec;
        r_nib_cnt <= r_nib_cnt + 1'b1;
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  v_hier_word_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (bus.level),
    .o_data  (bus.out_data)
  );

  assign bus.out_vld = !w_empty;
  assign bus.ovf     = r_ovf;
endmodule
